// File: rtl/wb_master_cmd.sv
`default_nettype none
// ============================================================================
// Module  : wb_master_cmd
// Brief   : Single-outstanding Wishbone classic initiator driven by a
//           valid/ready command channel, with response channel and bus timeout.
// Revision: 1.0 - initial release
// ============================================================================
module wb_master_cmd #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [AW-1:0]     cmd_adr_i,
  input  logic [DW-1:0]     cmd_dat_i,
  input  logic [DW/8-1:0]   cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              busy_o
);

  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen during the last permitted stb cycle without ack
  localparam logic [CW-1:0] C_CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CW-1:0]   r_cnt;
  logic            w_timeout;
  logic            r_cmd_ready;
  logic            r_rsp_valid;
  logic            r_cyc;
  logic            r_busy;
  logic            r_we;
  logic [SW-1:0]   r_sel;
  logic [AW-1:0]   r_adr;
  logic [DW-1:0]   r_dat;
  logic [DW-1:0]   r_rsp_dat;
  logic            r_rsp_err;

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == C_CNT_LAST);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (cmd_valid_i)              w_next_state = BUS;
      BUS:     if (wbm_ack_i || w_timeout)   w_next_state = RESP;
      RESP:    if (rsp_ready_i)              w_next_state = IDLE;
      default:                               w_next_state = IDLE;
    endcase
  end

  // Handshake and bus-control flags are registered from the next state so
  // every output comes straight from a flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_cyc       <= 1'b0;
      r_busy      <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == IDLE);
      r_rsp_valid <= (w_next_state == RESP);
      r_cyc       <= (w_next_state == BUS);
      r_busy      <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (cmd_valid_i) begin
            r_we  <= cmd_we_i;
            r_sel <= cmd_sel_i;
            r_adr <= cmd_adr_i;
            r_dat <= cmd_dat_i;
            r_cnt <= '0;
          end
        end
        BUS: begin
          // Ack takes priority over a timeout reached in the same cycle
          if (wbm_ack_i) begin
            r_rsp_dat <= r_we ? '0 : wbm_dat_i;
            r_rsp_err <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (wbm_ack_i || w_timeout) begin
            r_we  <= 1'b0;
            r_sel <= '0;
            r_adr <= '0;
            r_dat <= '0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_cmd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_wb_master_cmd
// Brief   : Scoreboard bench for wb_master_cmd with a programmable-latency slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_master_cmd;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [DW-1:0] cmd_dat_i = '0;
  logic [SW-1:0] cmd_sel_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;
  logic          busy_o;

  always #5 clk = ~clk;

  wb_master_cmd #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy_o(busy_o)
  );

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          err;
  } rsp_t;

  rsp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Slave: acks on stb cycle index ack_delay (0 = first cycle, -1 = never)
  int            ack_delay = 0;
  logic [DW-1:0] slave_rdata = '0;
  logic          spurious = 1'b0;
  int            stb_cnt = 0;
  int            stb_cycles = 0;
  logic          adr_changed = 1'b0;
  logic [AW-1:0] first_adr = '0;

  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      if (wbm_cyc_o && wbm_stb_o) begin
        if (stb_cnt == 0) begin
          first_adr   = wbm_adr_o;
          adr_changed = 1'b0;
        end else if (wbm_adr_o !== first_adr) begin
          adr_changed = 1'b1;
        end
        stb_cycles = stb_cnt + 1;
        wbm_ack_i  = (ack_delay >= 0) && (stb_cnt == ack_delay);
        wbm_dat_i  = wbm_ack_i ? slave_rdata : 32'hDEAD_BEEF;
        stb_cnt++;
      end else begin
        stb_cnt   = 0;
        wbm_ack_i = spurious;
        wbm_dat_i = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    int guard = 0;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    while (!cmd_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_accept: cmd_ready got %b required 1", cmd_ready_o);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic collect();
    int   guard = 0;
    rsp_t exp;
    while (!rsp_valid_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (rsp_valid_o !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rsp_wait: rsp_valid got %b queue %0d required 1/nonempty",
               rsp_valid_o, sb.size());
    end else begin
      exp = sb.pop_front();
      n_cmp++;
      if ({rsp_dat_o, rsp_err_o} !== exp) begin
        n_fail++;
        $display("FAIL rsp_data: got dat=%h err=%b required dat=%h err=%b",
                 rsp_dat_o, rsp_err_o, exp.dat, exp.err);
      end
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    n_cmp++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b required 0/1",
               rsp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b required 1/0/0",
               cmd_ready_o, busy_o, rsp_valid_o);
    end
    n_cmp++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc=%b stb=%b adr=%h dat=%h required all 0",
               wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_dat_o);
    end
    n_cmp++;
    if (rsp_dat_o !== '0 || rsp_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: dat=%h err=%b required 0/0", rsp_dat_o, rsp_err_o);
    end
  endtask

  task automatic test_write();
    ack_delay = 0;
    sb.push_back({32'h0, 1'b0});
    issue(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    n_cmp++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o} !== 4'b1111) begin
      n_fail++;
      $display("FAIL wr_ctrl: cyc/stb/we/busy got %b%b%b%b required 1111",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o);
    end
    n_cmp++;
    if (wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'hA5A5_1234 || wbm_sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_bus: adr=%h dat=%h sel=%h required 30000004/a5a51234/f",
               wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b1 || wbm_adr_o !== '0) begin
      n_fail++;
      $display("FAIL wr_latency: cyc=%b stb=%b rsp_valid=%b adr=%h required 0/0/1/0",
               wbm_cyc_o, wbm_stb_o, rsp_valid_o, wbm_adr_o);
    end
    collect();
    n_cmp++;
    if (stb_cycles != 1) begin
      n_fail++;
      $display("FAIL wr_stb_len: got %0d required 1", stb_cycles);
    end
  endtask

  task automatic test_read_wait();
    ack_delay   = 3;
    slave_rdata = 32'hCAFE_F00D;
    sb.push_back({32'hCAFE_F00D, 1'b0});
    issue(1'b0, 32'h3000_0000, 32'h5555_5555, 4'hF);
    n_cmp++;
    if (wbm_we_o !== 1'b0 || wbm_adr_o !== 32'h3000_0000) begin
      n_fail++;
      $display("FAIL rd_bus: we=%b adr=%h required 0/30000000", wbm_we_o, wbm_adr_o);
    end
    collect();
    n_cmp++;
    if (stb_cycles != 4 || adr_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_stb: len=%0d adr_changed=%b required 4/0", stb_cycles, adr_changed);
    end
  endtask

  task automatic test_timeout();
    ack_delay = -1;
    sb.push_back({32'h0, 1'b1});
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    collect();
    n_cmp++;
    if (stb_cycles != TO) begin
      n_fail++;
      $display("FAIL to_stb_len: got %0d required %0d", stb_cycles, TO);
    end
    ack_delay = 0;
    sb.push_back({32'h0, 1'b0});
    issue(1'b1, 32'h3000_000C, 32'h0000_00FF, 4'h1);
    collect();
  endtask

  task automatic test_ack_at_limit();
    ack_delay   = TO - 1;
    slave_rdata = 32'h1234_5678;
    sb.push_back({32'h1234_5678, 1'b0});
    issue(1'b0, 32'h3000_0018, 32'h0, 4'hF);
    collect();
    n_cmp++;
    if (stb_cycles != TO) begin
      n_fail++;
      $display("FAIL lim_stb_len: got %0d required %0d", stb_cycles, TO);
    end
  endtask

  task automatic test_back_to_back();
    rsp_t exp;
    ack_delay   = 0;
    slave_rdata = 32'h0BAD_F00D;
    sb.push_back({32'h0BAD_F00D, 1'b0});
    issue(1'b0, 32'h3000_0010, 32'h0, 4'h3);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h3000_0014;
    cmd_dat_i   = 32'h1111_2222;
    cmd_sel_i   = 4'h0;
    sb.push_back({32'h0, 1'b0});
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0BAD_F00D || rsp_err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold[%0d]: valid=%b dat=%h err=%b required 1/0badf00d/0",
                 i, rsp_valid_o, rsp_dat_o, rsp_err_o);
      end
      n_cmp++;
      if (cmd_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_block[%0d]: ready=%b cyc=%b required 0/0", i, cmd_ready_o, wbm_cyc_o);
      end
      @(posedge clk); #1;
    end
    exp = sb.pop_front();
    n_cmp++;
    if ({rsp_dat_o, rsp_err_o} !== exp) begin
      n_fail++;
      $display("FAIL b2b_rsp: got dat=%h err=%b required dat=%h err=%b",
               rsp_dat_o, rsp_err_o, exp.dat, exp.err);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || wbm_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: ready=%b cyc=%b rsp_valid=%b required 1/0/0",
               cmd_ready_o, wbm_cyc_o, rsp_valid_o);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_adr_o !== 32'h3000_0014 ||
        wbm_sel_o !== 4'h0 || wbm_dat_o !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL b2b_second: cyc=%b we=%b adr=%h sel=%h dat=%h required 1/1/30000014/0/11112222",
               wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o);
    end
    collect();
  endtask

  task automatic test_reset_mid();
    ack_delay = -1;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b0 ||
        cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || wbm_adr_o !== '0) begin
      n_fail++;
      $display("FAIL rst_async: cyc=%b stb=%b rsp_valid=%b ready=%b busy=%b required 0/0/0/1/0",
               wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o, busy_o);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    ack_delay = 0;
    spurious  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL spurious_ack[%0d]: rsp_valid=%b busy=%b cyc=%b ready=%b required 0/0/0/1",
                 i, rsp_valid_o, busy_o, wbm_cyc_o, cmd_ready_o);
      end
    end
    spurious = 1'b0;
    @(posedge clk); #1;
    slave_rdata = 32'h7777_8888;
    sb.push_back({32'h7777_8888, 1'b0});
    issue(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    collect();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_write();
    test_read_wait();
    test_timeout();
    test_ack_at_limit();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
